jk_command_encoder: RTL and testbench

- Drive side of the J/K latch interface. Accepts one hold/close/open/toggle request at a time through a valid/ready handshake.
- Encodes each request into a single-cycle j/k excitation pulse for a downstream JK latch, such as the irrigation valve state latch.
- Reads back the latch q, confirms the intended state was reached, and retries by forced set/reset if it was not.
- Reports done or error and keeps a sticky error flag for the irrigation controller.

---
 rtl/jk_command_encoder.sv | 177 +++++++++++++++++
 tb/tb_jk_command_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_command_encoder.sv
// -----------------------------------------------------------------------------
// jk_command_encoder
//
// Drive side of a J/K latch interface. Accepts one hold/close/open/toggle
// request at a time, turns it into a single-cycle j/k excitation pulse for a
// downstream JK latch, reads the latch q back after a settle window, and
// retries with a forced set/reset when the intended state was not reached.
// Reports done or error as one-cycle pulses and keeps a sticky error flag.
//
// Parameters:
//   SETTLE_CYCLES  idle cycles between a drive pulse and the q_fb check (>=1)
//   MAX_RETRIES    extra drive attempts after the first one fails
//   RETRY_W        width of retry_count, must hold MAX_RETRIES
//
// Ports:
//   clk          in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   req_valid    in   request present
//   req_cmd      in   00 hold, 01 close (q->0), 10 open (q->1), 11 toggle
//   req_ready    out  high in IDLE; accept on req_valid & req_ready
//   q_fb         in   q of the downstream JK latch (synchronous to clk)
//   j, k         out  registered J/K excitation, non-zero only in DRIVE
//   busy         out  high in any state other than IDLE
//   done         out  one-cycle pulse, target state confirmed
//   error        out  one-cycle pulse, retries exhausted
//   err_sticky   out  set by error, cleared by err_ack
//   err_ack      in   clears err_sticky
//   retry_count  out  retries used by the current or last request
// -----------------------------------------------------------------------------
module jk_command_encoder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_RETRIES   = 2,
  parameter int unsigned RETRY_W       = 2
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               req_valid,
  input  logic [1:0]         req_cmd,
  output logic               req_ready,
  input  logic               q_fb,
  output logic               j,
  output logic               k,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               err_sticky,
  input  logic               err_ack,
  output logic [RETRY_W-1:0] retry_count
);

  // Settle counter loads SETTLE_CYCLES-1 and counts down to zero.
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck
  } state_t;

  state_t             r_state;
  logic               r_target;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_j;
  logic               r_k;
  logic               r_done;
  logic               r_error;
  logic               r_sticky;

  logic w_match;
  logic w_can_retry;
  logic w_set_err;
  logic w_req_target;

  assign w_match     = (q_fb == r_target);
  assign w_can_retry = (r_retry < RETRY_MAX);
  assign w_set_err   = (r_state == StCheck) && !w_match && !w_can_retry;

  // Target for a new request: hold keeps the present q, toggle inverts it,
  // close/open use the explicit level carried in req_cmd[1].
  always_comb begin
    w_req_target = req_cmd[1];
    if (req_cmd == 2'b00) begin
      w_req_target = q_fb;
    end else if (req_cmd == 2'b11) begin
      w_req_target = ~q_fb;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state      <= StIdle;
      r_target     <= 1'b0;
      r_settle_cnt <= '0;
      r_retry      <= '0;
      r_j          <= 1'b0;
      r_k          <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_sticky     <= 1'b0;
    end else begin
      // Pulses and excitation default low; only specific transitions raise them.
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;

      // Set wins over acknowledge, including an ack that lands in the error cycle.
      if (w_set_err) begin
        r_sticky <= 1'b1;
      end else if (err_ack && !r_error) begin
        r_sticky <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_retry  <= '0;
            r_target <= w_req_target;
            if (req_cmd == 2'b00) begin
              r_state <= StCheck;
            end else begin
              r_state <= StDrive;
              r_j     <= req_cmd[1];
              r_k     <= req_cmd[0];
            end
          end
        end

        StDrive: begin
          r_settle_cnt <= SETTLE_LOAD;
          r_state      <= StSettle;
        end

        StSettle: begin
          if (r_settle_cnt == '0) begin
            r_state <= StCheck;
          end else begin
            r_settle_cnt <= r_settle_cnt - CNT_W'(1);
          end
        end

        StCheck: begin
          if (w_match) begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else if (w_can_retry) begin
            // Retries force set/reset so a late-settling latch is never
            // toggled twice.
            r_retry <= r_retry + RETRY_W'(1);
            r_j     <= r_target;
            r_k     <= ~r_target;
            r_state <= StDrive;
          end else begin
            r_error <= 1'b1;
            r_state <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready   = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign j           = r_j;
  assign k           = r_k;
  assign done        = r_done;
  assign error       = r_error;
  assign err_sticky  = r_sticky;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_jk_command_encoder.sv
module tb_jk_command_encoder;

  localparam int unsigned S    = 4;
  localparam int unsigned MAXR = 2;
  localparam int unsigned RW   = 2;

  logic          clk = 1'b0;
  logic          clear;
  logic          req_valid;
  logic [1:0]    req_cmd;
  logic          req_ready;
  logic          q_fb;
  logic          j;
  logic          k;
  logic          busy;
  logic          done;
  logic          error;
  logic          err_sticky;
  logic          err_ack;
  logic [RW-1:0] retry_count;

  jk_command_encoder #(
    .SETTLE_CYCLES(S),
    .MAX_RETRIES  (MAXR),
    .RETRY_W      (RW)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_ready  (req_ready),
    .q_fb       (q_fb),
    .j          (j),
    .k          (k),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_sticky (err_sticky),
    .err_ack    (err_ack),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream JK latch plant with fault injection: dropped pulses or stuck.
  logic plant_q;
  int   plant_drops;
  bit   plant_stuck;
  assign q_fb = plant_q;

  always @(posedge clk) begin
    if ((j || k) && !plant_stuck) begin
      if (plant_drops > 0) plant_drops <= plant_drops - 1;
      else plant_q <= (j && k) ? ~plant_q : j;
    end
  end

  typedef struct {
    int         cyc;
    logic [1:0] jk;
  } pulse_t;

  typedef struct {
    bit err;
    int retry;
    int cyc;
  } resp_t;

  pulse_t pulse_q[$];
  resp_t  resp_q[$];

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int resp_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: walks the attempts of one request at the level of
  // "which pulse is applied and what q becomes", pushing expected pulses and
  // the expected response. a = cycle right after the accepting edge.
  function automatic void model(input logic [1:0] cmd, input logic q0, input int drops,
                                input bit stuck, input int a);
    logic       tgt;
    logic       q;
    logic [1:0] jkv;
    int         d;
    resp_t      r;
    pulse_t     p;
    case (cmd)
      2'b01:   tgt = 1'b0;
      2'b10:   tgt = 1'b1;
      2'b11:   tgt = ~q0;
      default: tgt = q0;
    endcase
    if (cmd == 2'b00) begin
      r.err = 0; r.retry = 0; r.cyc = a + 1;
      resp_q.push_back(r);
      return;
    end
    q = q0;
    d = drops;
    for (int n = 0; n <= int'(MAXR); n++) begin
      jkv   = (n == 0) ? cmd : {tgt, ~tgt};
      p.cyc = a + n * int'(S + 2);
      p.jk  = jkv;
      pulse_q.push_back(p);
      if (!stuck) begin
        if (d > 0) d--;
        else q = (jkv == 2'b11) ? ~q : jkv[1];
      end
      if (q == tgt) begin
        r.err = 0; r.retry = n; r.cyc = a + 2 + int'(S) + n * int'(S + 2);
        resp_q.push_back(r);
        return;
      end
    end
    r.err = 1; r.retry = int'(MAXR); r.cyc = a + 2 + int'(S) + int'(MAXR) * int'(S + 2);
    resp_q.push_back(r);
  endfunction

  // Monitor: compares every pulse and every done/error against the queues.
  always @(negedge clk) begin
    pulse_t p;
    resp_t  r;
    if (!clear) begin
      if (j || k) begin
        if (pulse_q.size() == 0) begin
          chk("unexpected_pulse", 32'({j, k}), 32'd0);
        end else begin
          p = pulse_q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(p.cyc));
          chk("pulse_jk", 32'({j, k}), 32'(p.jk));
        end
      end
      if (done || error) begin
        resp_seen++;
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'({done, error}), 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_kind", 32'({done, error}), r.err ? 32'd1 : 32'd2);
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("retry_count", 32'(retry_count), 32'(r.retry));
          if (r.err) chk("err_sticky_set", 32'(err_sticky), 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && resp_q.size() == 0 && pulse_q.size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL wait_idle: timeout, got busy expected idle");
        $fatal(1);
      end
    end
  endtask

  // Issue one request from a negedge; returns the cycle right after acceptance.
  task automatic issue(input logic [1:0] cmd, input int drops, input bit stk, output int a);
    wait_idle();
    plant_drops = drops;
    plant_stuck = stk;
    a = cyc + 1;
    model(cmd, plant_q, drops, stk, a);
    req_valid = 1'b1;
    req_cmd   = cmd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    int n = 0;
    while (cyc != c) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL wait_cycle: timeout, got %0d expected %0d", cyc, c);
        $fatal(1);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a;
    int seen;
    clear       = 1'b1;
    req_valid   = 1'b0;
    req_cmd     = 2'b00;
    err_ack     = 1'b0;
    plant_q     = 1'b0;
    plant_drops = 0;
    plant_stuck = 0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jk", 32'({j, k}), 32'd0);
    chk("rst_done_err", 32'({done, error}), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // Set on a clean latch, then toggle from q=1, then toggle with a lost pulse.
    issue(2'b10, 0, 0, a);
    issue(2'b11, 0, 0, a);
    issue(2'b11, 1, 0, a);
    wait_idle();
    chk("lost_pulse_q", 32'(plant_q), 32'd1);

    // Stuck actuator, then acknowledge in an idle cycle.
    plant_q = 1'b0;
    issue(2'b10, 0, 1, a);
    wait_idle();
    chk("sticky_held", 32'(err_sticky), 32'd1);
    err_ack = 1'b1;
    @(negedge clk);
    err_ack = 1'b0;
    chk("sticky_acked", 32'(err_sticky), 32'd0);

    // Stuck again with err_ack asserted during the error cycle: set wins.
    issue(2'b10, 0, 1, a);
    wait_cycle(a + 2 + int'(S) + int'(MAXR) * int'(S + 2));
    err_ack = 1'b1;
    @(negedge clk);
    err_ack = 1'b0;
    chk("sticky_ack_same_cycle", 32'(err_sticky), 32'd1);

    // Hold followed by a back-to-back close accepted on the done edge.
    wait_idle();
    plant_drops = 0;
    plant_stuck = 0;
    a = cyc + 1;
    model(2'b00, plant_q, 0, 0, a);
    model(2'b01, plant_q, 0, 0, a + 2);
    req_valid = 1'b1;
    req_cmd   = 2'b00;
    @(negedge clk);
    chk("hold_not_ready", 32'(req_ready), 32'd0);
    req_cmd = 2'b01;
    @(negedge clk);
    chk("b2b_ready_in_done", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;

    // Asynchronous clear in the middle of SETTLE abandons the request.
    issue(2'b10, 0, 0, a);
    wait_cycle(a + 2);
    #2;
    clear = 1'b1;
    resp_q.delete();
    pulse_q.delete();
    #1;
    chk("async_jk", 32'({j, k}), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd1);
    chk("async_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    seen = resp_seen;
    repeat (15) @(negedge clk);
    chk("no_resp_after_clear", 32'(resp_seen), 32'(seen));
    issue(2'b01, 0, 0, a);

    // Randomized requests with random latch faults.
    for (int i = 0; i < 40; i++) begin
      int unsigned mode;
      logic [1:0]  cmd;
      cmd  = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      issue(cmd, (mode >= 6) ? int'(mode) - 6 : 0, (mode == 0), a);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pulse_q_empty", 32'(pulse_q.size()), 32'd0);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
